memoria_principal_ctrl: RTL and testbench
=========================================

// Module: memoria_principal_ctrl
// PURPOSE
//  Main-memory responder on the memory side of memoriaCache. On a cache miss it
//  accepts one request: an optional dirty-victim write-back plus a block refill.
//  It commits the write-back to a DEPTH x DATA_W backing array, then reads the
//  refill word. Each access is a fixed multi-cycle operation. The refill is
//  returned with a one-cycle response strobe.
// PARAMETERS
//  ADDR_W   5   address width (matches cache address bus)
//  DATA_W   3   word width (matches cache data bus)
//  LATENCY  4   cycles per memory access, legal range 1..15
//  DEPTH    1<<ADDR_W  number of backing words (derived; do not override)
// PORTS
//  clock        in   1       single clock, rising edge
//  reset        in   1       asynchronous, active-high
//  req_valid    in   1       miss request strobe; sampled only in IDLE
//  req_address  in   ADDR_W  refill address
//  wb_valid     in   1       request carries a dirty victim to write first
//  wb_address   in   ADDR_W  victim address
//  wb_data      in   DATA_W  victim data
//  busy         out  1       high while a request is in progress
//  wb_done      out  1       one-cycle pulse: write-back committed to array
//  resp_valid   out  1       one-cycle pulse: resp_data holds refill word
//  resp_data    out  DATA_W  refill word; holds until next response
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, busy=0, wb_done=0, resp_valid=0, resp_data=0.
//    The array is initialised per CONFIGURATION.
//  - FSM states: IDLE, WB, RD, RESP.
//    - IDLE, req_valid=1 at edge E0: latch req_address, wb_valid, wb_address
//      and wb_data. Go to WB if wb_valid=1, else RD. Load cnt=LATENCY-1.
//    - WB: cnt decrements each edge. On the edge where cnt==0: write
//      mem[wb_addr]<=wb_data, pulse wb_done for the next cycle, go to RD,
//      reload cnt=LATENCY-1.
//    - RD: cnt decrements each edge. On the edge where cnt==0: load
//      resp_data<=mem[req_addr] (read after any same-request write), go to RESP.
//    - RESP: resp_valid=1 for exactly one cycle, busy=1. Next edge returns to IDLE.
//  - busy is a registered output: 1 in WB/RD/RESP, 0 in IDLE.
//  - Latency from request edge E0:
//    - No write-back: resp_valid rises at E_LATENCY; busy spans LATENCY+1 cycles.
//    - With write-back: wb_done rises at E_LATENCY; resp_valid rises at E_2*LATENCY.
//  - wb_address==req_address: the refill returns the just-written wb_data.
//  - req_valid or input changes while busy are ignored. The request is latched
//    only at E0, so there is no queuing.
//  - A new request is accepted in IDLE only. The earliest is the edge after the
//    RESP cycle, which gives back-to-back throughput.
//  - LATENCY=1: WB and RD each last one cycle.
//  - Reset mid-operation: immediate return to IDLE with all outputs 0.
//    - An uncommitted write-back is discarded; the array is untouched.
//    - The array is re-initialised as for any reset.
// CONFIGURATION
//  MEM_INIT_EN defined: reset loads mem[i] = i[DATA_W-1:0] (address-derived
//    pattern, e.g. mem[5'b01101]=3'b101).
//  MEM_INIT_EN undefined: reset clears every mem[i] to 0.
//  No other behaviour differs.
// TESTING  (LATENCY=4, MEM_INIT_EN defined unless noted)
//  1 reset; req 5'b10000, wb_valid=0 -> busy 5 cycles, resp_valid at E4,
//    resp_data=0.
//  2 req 5'b00001, wb_valid=0 -> resp_valid at E4, resp_data=1; no wb_done pulse.
//  3 req 5'b01001 + wb 5'b00001/3'b101 -> wb_done at E4, resp_valid at E8,
//    resp_data=1; then read 5'b00001 -> 5.
//  4 req 5'b01101 + wb 5'b01101/3'b001 -> resp_data=1 (not init value 5).
//  5 req 5'b00101 accepted; req_valid held with 5'b01101 during busy
//    -> single resp_valid with resp_data=5.
//  6 reset at E2 of WB (wb 5'b00001/3'b110) -> busy=0 at once, no wb_done;
//    reread 5'b00001 -> 1. Undefined MEM_INIT_EN: same read -> 0.

Source files
------------

// File: rtl/memoria_principal_ctrl_if.sv
// Purpose: request/write-back/response bundle between the cache miss handler
//          (master) and the main-memory controller (slave).
// Signals:
//   req_valid, req_address           refill request from the cache
//   wb_valid, wb_address, wb_data    optional dirty victim carried with it
//   busy, wb_done                    controller status
//   resp_valid, resp_data            refill word return
interface memoria_principal_ctrl_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 3
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_address;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_address;
    logic [DATA_W-1:0] wb_data;
    logic              busy;
    logic              wb_done;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;

    modport master (
        output req_valid, req_address, wb_valid, wb_address, wb_data,
        input  busy, wb_done, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_address, wb_valid, wb_address, wb_data,
        output busy, wb_done, resp_valid, resp_data
    );
endinterface

// File: rtl/memoria_principal_ctrl.sv
// Purpose: main-memory responder behind the cache. Accepts one miss request
//          in IDLE, optionally commits a dirty-victim write-back, then reads
//          the refill word and returns it with a one-cycle strobe. Each
//          memory access takes LATENCY cycles.
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous, active-high
//   bus     slave side of memoria_principal_ctrl_if (request, write-back,
//           busy / wb_done / resp_valid / resp_data; all outputs registered)
// Build option:
//   MEM_INIT_EN  defined   -> reset loads mem[i] = i (truncated to DATA_W)
//                undefined -> reset clears the array
module memoria_principal_ctrl #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 3,
    parameter int unsigned LATENCY = 4
) (
    input logic                    clock,
    input logic                    reset,
    memoria_principal_ctrl_if.slave bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_RD   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [ADDR_W-1:0] req_addr_q,   req_addr_d;
    logic [ADDR_W-1:0] wb_addr_q,    wb_addr_d;
    logic [DATA_W-1:0] wb_data_q,    wb_data_d;
    logic              busy_q,       busy_d;
    logic              wb_done_q,    wb_done_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q,  resp_data_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Next-state, datapath and output decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_addr_d   = req_addr_q;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;
        busy_d       = busy_q;
        wb_done_d    = 1'b0;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        mem_d        = mem_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (bus.req_valid) begin
                    // Whole request is captured here; later input changes are ignored
                    req_addr_d = bus.req_address;
                    wb_addr_d  = bus.wb_address;
                    wb_data_d  = bus.wb_data;
                    cnt_d      = CNT_RELOAD;
                    busy_d     = 1'b1;
                    state_d    = bus.wb_valid ? S_WB : S_RD;
                end
            end
            S_WB: begin
                if (cnt_q == '0) begin
                    mem_d[wb_addr_q] = wb_data_q;
                    wb_done_d        = 1'b1;
                    cnt_d            = CNT_RELOAD;
                    state_d          = S_RD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RD: begin
                if (cnt_q == '0) begin
                    // Any write-back for this request committed on an earlier edge
                    resp_data_d  = mem_q[req_addr_q];
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            req_addr_q   <= '0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            busy_q       <= 1'b0;
            wb_done_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_addr_q   <= req_addr_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            busy_q       <= busy_d;
            wb_done_q    <= wb_done_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Backing array; every reset reloads its power-on contents
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
`ifdef MEM_INIT_EN
                mem_q[i] <= DATA_W'(i);
`else
                mem_q[i] <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.wb_done    = wb_done_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_memoria_principal_ctrl.sv
// Purpose: directed self-checking bench for memoria_principal_ctrl with
//          LATENCY=4. Expected refill words come from a reference memory
//          model and are queued at request time, popped on resp_valid.
module tb_memoria_principal_ctrl;

    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DATA_W  = 3;
    localparam int unsigned LATENCY = 4;
    localparam int unsigned DEPTH   = 1 << ADDR_W;

    logic clock;
    logic reset;

    memoria_principal_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    memoria_principal_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LATENCY(LATENCY)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] exp_q [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] init_val(input int i);
`ifdef MEM_INIT_EN
        return DATA_W'(i);
`else
        return DATA_W'(i & 0);
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = init_val(i);
    endtask

    // One request: drive before E0, then check outputs after every edge
    // E0..E(total+1). With hold=1, req_valid stays high with hold_addr while busy.
    task automatic issue(input string tag,
                         input logic [ADDR_W-1:0] ra,
                         input logic              wbv,
                         input logic [ADDR_W-1:0] wa,
                         input logic [DATA_W-1:0] wd,
                         input logic              hold,
                         input logic [ADDR_W-1:0] hold_addr);
        int unsigned total;
        logic [DATA_W-1:0] exp_data;
        total = wbv ? 2 * LATENCY : LATENCY;
        @(negedge clock);
        bus.req_valid   = 1'b1;
        bus.req_address = ra;
        bus.wb_valid    = wbv;
        bus.wb_address  = wa;
        bus.wb_data     = wd;
        if (wbv) model_mem[wa] = wd;
        exp_q.push_back(model_mem[ra]);
        for (int k = 0; k <= int'(total) + 1; k++) begin
            @(negedge clock);
            check({tag, "_busy"},    32'(bus.busy),       32'(k <= int'(total)));
            check({tag, "_wb_done"}, 32'(bus.wb_done),    32'(wbv && k == int'(LATENCY)));
            check({tag, "_rvalid"},  32'(bus.resp_valid), 32'(k == int'(total)));
            if (bus.resp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_unexpected_resp"}, 32'(1), 32'(0));
                end else begin
                    exp_data = exp_q.pop_front();
                    check({tag, "_rdata"}, 32'(bus.resp_data), 32'(exp_data));
                end
            end
            if (k == 0) begin
                bus.req_valid   = hold;
                bus.req_address = hold_addr;
                bus.wb_valid    = hold;
                bus.wb_address  = hold_addr;
                bus.wb_data     = ~wd;
            end
        end
        bus.req_valid = 1'b0;
        bus.wb_valid  = 1'b0;
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_address = '0;
        bus.wb_valid    = 1'b0;
        bus.wb_address  = '0;
        bus.wb_data     = '0;
        reset           = 1'b1;
        model_reset();

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_busy",    32'(bus.busy),       32'(0));
        check("rst_wb_done", 32'(bus.wb_done),    32'(0));
        check("rst_rvalid",  32'(bus.resp_valid), 32'(0));
        check("rst_rdata",   32'(bus.resp_data),  32'(0));
        reset = 1'b0;

        // Plain refills
        issue("t1", 5'b10000, 1'b0, 5'b00000, 3'b000, 1'b0, 5'b00000);
        issue("t2", 5'b00001, 1'b0, 5'b00000, 3'b000, 1'b0, 5'b00000);

        // Write-back to another address, then read it back
        issue("t3",  5'b01001, 1'b1, 5'b00001, 3'b101, 1'b0, 5'b00000);
        issue("t3b", 5'b00001, 1'b0, 5'b00000, 3'b000, 1'b0, 5'b00000);

        // Write-back to the refill address returns the new data
        issue("t4", 5'b01101, 1'b1, 5'b01101, 3'b001, 1'b0, 5'b00000);

        // Request held during busy must not be re-accepted
        issue("t5", 5'b00101, 1'b0, 5'b00000, 3'b000, 1'b1, 5'b01101);
        @(negedge clock);
        check("t5_idle_busy",   32'(bus.busy),       32'(0));
        check("t5_idle_rvalid", 32'(bus.resp_valid), 32'(0));

        // Reset in the middle of a write-back
        @(negedge clock);
        bus.req_valid   = 1'b1;
        bus.req_address = 5'b00010;
        bus.wb_valid    = 1'b1;
        bus.wb_address  = 5'b00001;
        bus.wb_data     = 3'b110;
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.wb_valid  = 1'b0;
        check("t6_busy_before", 32'(bus.busy), 32'(1));
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("t6_busy",    32'(bus.busy),       32'(0));
        check("t6_wb_done", 32'(bus.wb_done),    32'(0));
        check("t6_rvalid",  32'(bus.resp_valid), 32'(0));
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        issue("t6r", 5'b00001, 1'b0, 5'b00000, 3'b000, 1'b0, 5'b00000);

        check("sb_empty", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
